uart_rx: RTL and testbench

//  - 8N1 UART receiver; the far end of the serial link driven by the team's transmitter.
//  - Synchronises i_Rx_Serial, finds the start bit and samples each bit at mid-bit.
//  - Shifts data in LSB-first, checks the stop bit.
//  - Delivers each byte with a 1-cycle valid strobe.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver/transmitter state encoding.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_START   = 3'd1;
   localparam logic [2:0] ST_DATA    = 3'd2;
   localparam logic [2:0] ST_PARITY  = 3'd3;
   localparam logic [2:0] ST_STOP    = 3'd4;
   localparam logic [2:0] ST_CLEANUP = 3'd5;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      START   = ST_START,
      DATA    = ST_DATA,
      PARITY  = ST_PARITY,
      STOP    = ST_STOP,
      CLEANUP = ST_CLEANUP
   } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-line side of the UART receiver. o_Parity_Err exists only with UART_RX_PARITY_EN.
interface uart_rx_if;
   import uart_pkg::*;

   logic                      i_Rx_Serial;
   logic                      o_Rx_DV;
   logic [UART_DATA_BITS-1:0] o_Rx_Byte;
   logic                      o_Rx_Active;
   logic                      o_Frame_Err;
`ifdef UART_RX_PARITY_EN
   logic                      o_Parity_Err;
`endif

   modport master (
      output i_Rx_Serial,
`ifdef UART_RX_PARITY_EN
      input  o_Parity_Err,
`endif
      input  o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Frame_Err
   );

   modport slave (
      input  i_Rx_Serial,
`ifdef UART_RX_PARITY_EN
      output o_Parity_Err,
`endif
      output o_Rx_DV, o_Rx_Byte, o_Rx_Active, o_Frame_Err
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and 1-cycle DV / framing-error strobes.
// Optional even parity bit (and o_Parity_Err) with macro UART_RX_PARITY_EN.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   uart_rx_if.slave  bus
);

   localparam int MID_CNT = (CLKS_PER_BIT - 1) / 2;
   localparam int CNT_W   = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(MID_CNT);
   localparam logic [CNT_W-1:0] CNT_END = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_s;

   uart_rx_sync u_sync (.clk(clk), .rst_n(rst_n), .d(bus.i_Rx_Serial), .q(rx_s));

   uart_state_e               state, state_n;
   logic [CNT_W-1:0]          clk_cnt, cnt_n;
   logic [2:0]                bit_idx, idx_n;
   logic [UART_DATA_BITS-1:0] shift, shift_n, rx_byte, byte_n;
   logic                      dv, dv_n, ferr, ferr_n, active, active_n;
   // armed: line has been seen high since the last frame, so a held-low line cannot retrigger
   logic                      armed, armed_n;
`ifdef UART_RX_PARITY_EN
   logic                      par_bad, par_bad_n, perr, perr_n;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         clk_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         rx_byte <= '0;
         dv      <= 1'b0;
         ferr    <= 1'b0;
         active  <= 1'b0;
         armed   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
         perr    <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         clk_cnt <= cnt_n;
         bit_idx <= idx_n;
         shift   <= shift_n;
         rx_byte <= byte_n;
         dv      <= dv_n;
         ferr    <= ferr_n;
         active  <= active_n;
         armed   <= armed_n;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_n;
         perr    <= perr_n;
`endif
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = clk_cnt;
      idx_n     = bit_idx;
      shift_n   = shift;
      byte_n    = rx_byte;
      dv_n      = 1'b0;
      ferr_n    = 1'b0;
      active_n  = active;
      armed_n   = armed;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      perr_n    = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rx_s) begin
               armed_n = 1'b1;
            end else if (armed) begin
               state_n  = START;
               cnt_n    = '0;
               active_n = 1'b1;
            end
         end
         START: begin
            if (clk_cnt == CNT_MID) begin
               if (!rx_s) begin
                  state_n = DATA;
                  cnt_n   = '0;
                  idx_n   = '0;
               end else begin
                  state_n  = IDLE;
                  active_n = 1'b0;
               end
            end else begin
               cnt_n = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (clk_cnt == CNT_END) begin
               shift_n[bit_idx] = rx_s;
               cnt_n            = '0;
               if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = bit_idx + 3'd1;
               end
            end else begin
               cnt_n = clk_cnt + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (clk_cnt == CNT_END) begin
               par_bad_n = ^{shift, rx_s};
               cnt_n     = '0;
               state_n   = STOP;
            end else begin
               cnt_n = clk_cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            if (clk_cnt == CNT_END) begin
               state_n = CLEANUP;
               if (!rx_s) begin
                  ferr_n = 1'b1;
`ifdef UART_RX_PARITY_EN
               end else if (par_bad) begin
                  perr_n = 1'b1;
`endif
               end else begin
                  dv_n   = 1'b1;
                  byte_n = shift;
               end
            end else begin
               cnt_n = clk_cnt + 1'b1;
            end
         end
         CLEANUP: begin
            state_n  = IDLE;
            cnt_n    = '0;
            active_n = 1'b0;
            armed_n  = 1'b0;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.o_Rx_DV     = dv;
   assign bus.o_Rx_Byte   = rx_byte;
   assign bus.o_Rx_Active = active;
   assign bus.o_Frame_Err = ferr;
`ifdef UART_RX_PARITY_EN
   assign bus.o_Parity_Err = perr;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame-level event model plus per-cycle output compare.
module tb_uart_rx;

   localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
   localparam int NPB = 1;
   localparam int LAT = 171;
`else
   localparam int NPB = 0;
   localparam int LAT = 155;
`endif
   localparam int K_DV = 0, K_FERR = 1, K_PERR = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   uart_rx_if bus ();

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      int         at;
      logic [7:0] b;
   } ev_t;

   ev_t        q[$];
   int         n_vec = 0, n_bad = 0;
   int         dv_cnt = 0, ferr_cnt = 0, perr_cnt = 0, first_dv_at = -1;
   logic [7:0] last_byte = 8'h00;
   logic       perr_s;

`ifdef UART_RX_PARITY_EN
   assign perr_s = bus.o_Parity_Err;
`else
   assign perr_s = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic match(input int kind, input string nm);
      if (q.size() == 0) begin
         chk({nm, "_unexpected"}, 32'd1, 32'd0);
      end else begin
         chk({nm, "_kind"}, 32'(q[0].kind), 32'(kind));
         chk({nm, "_time"}, 32'(cyc >= q[0].at - 1 && cyc <= q[0].at + 1), 32'd1);
         if (kind == K_DV) begin
            chk({nm, "_byte"}, 32'(bus.o_Rx_Byte), 32'(q[0].b));
            last_byte = q[0].b;
         end
         void'(q.pop_front());
      end
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset_outputs", 32'({bus.o_Rx_DV, bus.o_Frame_Err, bus.o_Rx_Active, perr_s, bus.o_Rx_Byte}), 32'd0);
      end else begin
         if (bus.o_Rx_DV) begin
            dv_cnt++;
            if (first_dv_at < 0) first_dv_at = cyc;
            match(K_DV, "dv");
         end
         if (bus.o_Frame_Err) begin
            ferr_cnt++;
            match(K_FERR, "ferr");
         end
         if (perr_s) begin
            perr_cnt++;
            match(K_PERR, "perr");
         end
         if (q.size() > 0 && cyc > q[0].at + 1) begin
            chk("event_missing", 32'd0, 32'd1);
            void'(q.pop_front());
         end
         chk("byte_hold", 32'(bus.o_Rx_Byte), 32'(last_byte));
         chk("strobe_excl", 32'(32'(bus.o_Rx_DV) + 32'(bus.o_Frame_Err) + 32'(perr_s) > 1), 32'd0);
      end
   end

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v);
      bus.i_Rx_Serial = v;
      idle(CPB);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par);
      ev_t e;
      e.at = cyc + LAT;
      e.b  = b;
      if (!stop)                           e.kind = K_FERR;
      else if (NPB == 1 && (^{b, par}))    e.kind = K_PERR;
      else                                 e.kind = K_DV;
      q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      if (NPB == 1) drive_bit(par);
      drive_bit(stop);
      bus.i_Rx_Serial = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: cycle %0d, expected finish before 20000", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int         t0;
      logic [7:0] b55;
      bus.i_Rx_Serial = 1'b1;
      rst_n = 1'b0;
      idle(4);
      rst_n = 1'b1;
      idle(5);
      chk("post_reset_active", 32'(bus.o_Rx_Active), 32'd0);

      t0 = cyc;
      send_frame(8'hA5, 1'b1, ^8'hA5);
      idle(40);
      chk("a5_byte", 32'(bus.o_Rx_Byte), 32'h0000_00A5);
      chk("a5_dv_cnt", 32'(dv_cnt), 32'd1);
      chk("a5_ferr_cnt", 32'(ferr_cnt), 32'd0);
      chk("a5_latency", 32'(first_dv_at >= t0 + LAT - 1 && first_dv_at <= t0 + LAT + 1), 32'd1);

      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      idle(40);
      chk("b2b_dv_cnt", 32'(dv_cnt), 32'd3);
      chk("b2b_byte", 32'(bus.o_Rx_Byte), 32'h0000_00FF);

      bus.i_Rx_Serial = 1'b0;
      idle(3);
      bus.i_Rx_Serial = 1'b1;
      idle(3);
      chk("glitch_active_hi", 32'(bus.o_Rx_Active), 32'd1);
      idle(20);
      chk("glitch_active_lo", 32'(bus.o_Rx_Active), 32'd0);
      chk("glitch_dv_cnt", 32'(dv_cnt), 32'd3);
      chk("glitch_ferr_cnt", 32'(ferr_cnt), 32'd0);

      send_frame(8'h3C, 1'b0, ^8'h3C);
      idle(40);
      chk("ferr_cnt", 32'(ferr_cnt), 32'd1);
      chk("ferr_dv_cnt", 32'(dv_cnt), 32'd3);
      chk("ferr_byte_kept", 32'(bus.o_Rx_Byte), 32'h0000_00FF);

      b55 = 8'h55;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(b55[i]);
      bus.i_Rx_Serial = b55[4];
      idle(CPB / 2);
      rst_n = 1'b0;
      q.delete();
      last_byte = 8'h00;
      bus.i_Rx_Serial = 1'b1;
      idle(5);
      chk("rst_byte", 32'(bus.o_Rx_Byte), 32'd0);
      chk("rst_active", 32'(bus.o_Rx_Active), 32'd0);
      rst_n = 1'b1;
      idle(CPB * 12);
      chk("rst_no_dv", 32'(dv_cnt), 32'd3);
      send_frame(8'h81, 1'b1, ^8'h81);
      idle(40);
      chk("r81_byte", 32'(bus.o_Rx_Byte), 32'h0000_0081);
      chk("r81_dv_cnt", 32'(dv_cnt), 32'd4);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b0);
      idle(40);
      chk("par_bad_cnt", 32'(perr_cnt), 32'd1);
      chk("par_bad_dv_cnt", 32'(dv_cnt), 32'd4);
      chk("par_bad_byte", 32'(bus.o_Rx_Byte), 32'h0000_0081);
      send_frame(8'h07, 1'b1, 1'b1);
      idle(40);
      chk("par_ok_byte", 32'(bus.o_Rx_Byte), 32'h0000_0007);
      chk("par_ok_dv_cnt", 32'(dv_cnt), 32'd5);
      chk("par_ok_perr_cnt", 32'(perr_cnt), 32'd1);
`endif

      idle(50);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
